// File: rtl/lfsr_pkg.sv
// Shared types and constants for the LFSR comparator datapath: FSM state
// encoding and default maximal-length Galois masks for widths 3..16.
package lfsr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [15:0] MASK_W3  = 16'h0006;
  localparam logic [15:0] MASK_W4  = 16'h000C;
  localparam logic [15:0] MASK_W5  = 16'h0014;
  localparam logic [15:0] MASK_W6  = 16'h0030;
  localparam logic [15:0] MASK_W7  = 16'h0060;
  localparam logic [15:0] MASK_W8  = 16'h00B8;
  localparam logic [15:0] MASK_W9  = 16'h0110;
  localparam logic [15:0] MASK_W10 = 16'h0240;
  localparam logic [15:0] MASK_W11 = 16'h0500;
  localparam logic [15:0] MASK_W12 = 16'h0E08;
  localparam logic [15:0] MASK_W13 = 16'h1C80;
  localparam logic [15:0] MASK_W14 = 16'h3802;
  localparam logic [15:0] MASK_W15 = 16'h6000;
  localparam logic [15:0] MASK_W16 = 16'hD008;

  // Right-shift Galois masks; callers slice the low WIDTH bits.
  function automatic logic [15:0] default_mask(input int width);
    case (width)
      3:       return MASK_W3;
      4:       return MASK_W4;
      5:       return MASK_W5;
      6:       return MASK_W6;
      7:       return MASK_W7;
      8:       return MASK_W8;
      9:       return MASK_W9;
      10:      return MASK_W10;
      11:      return MASK_W11;
      12:      return MASK_W12;
      13:      return MASK_W13;
      14:      return MASK_W14;
      15:      return MASK_W15;
      16:      return MASK_W16;
      default: return 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/lfsr_pulse_gen_if.sv
// Operand/pulse bundle between a sweep requester and lfsr_pulse_gen.
interface lfsr_pulse_gen_if
  import lfsr_pkg::*;
#(
  parameter int WIDTH = 8
);
  // start is a level request with no ready: it is sampled only while the
  // generator is idle and acceptance shows as busy rising; while busy,
  // start and the operand buses are ignored. abort cancels a running sweep.
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] x_val;
  logic [WIDTH-1:0] y_val;
  logic             x_pulse;
  logic             y_pulse;
  logic             busy;
  logic             done;
  state_t           dbg_state;

  modport master (
    output start, abort, x_val, y_val,
    input  x_pulse, y_pulse, busy, done, dbg_state
  );

  modport slave (
    input  start, abort, x_val, y_val,
    output x_pulse, y_pulse, busy, done, dbg_state
  );
endinterface

// File: rtl/lfsr_galois.sv
// Right-shifting Galois LFSR with synchronous load of SEED and step enable.
module lfsr_galois #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] MASK  = WIDTH'(8'hB8),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             load,
  input  logic             en,
  output logic [WIDTH-1:0] state
);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state <= SEED;
    end else if (load) begin
      state <= SEED;
    end else if (en) begin
      state <= (state >> 1) ^ (state[0] ? MASK : '0);
    end
  end

endmodule

// File: rtl/lfsr_pulse_gen.sv
// Converts two operands into single-cycle pulses whose timing is the
// operand's position in a full Galois LFSR sweep.
module lfsr_pulse_gen
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] MASK  = WIDTH'(8'hB8),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
  input logic              clk,
  input logic              rst_b,
  lfsr_pulse_gen_if.slave  bus
);

  localparam logic [WIDTH-1:0] LAST_STEP = WIDTH'((1 << WIDTH) - 2);

  state_t           state;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q;
  logic [WIDTH-1:0] step_cnt;
  logic [WIDTH-1:0] lfsr;
  logic             lfsr_load;
  logic             lfsr_en;
  logic             x_hit;
  logic             y_hit;
  logic             x_pulse_q;
  logic             y_pulse_q;
  logic             busy_q;
  logic             done_q;

  assign lfsr_load = (state == IDLE) && bus.start;
  assign lfsr_en   = (state == RUN);

  lfsr_galois #(
    .WIDTH (WIDTH),
    .MASK  (MASK),
    .SEED  (SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_b (rst_b),
    .load  (lfsr_load),
    .en    (lfsr_en),
    .state (lfsr)
  );

  // Compare hits land in x_hit/y_hit, then in the output pulse registers;
  // a hit still in flight when the FSM has already returned to IDLE
  // (abort) is dropped so nothing appears after the sweep is cancelled.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state     <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      step_cnt  <= '0;
      x_hit     <= 1'b0;
      y_hit     <= 1'b0;
      x_pulse_q <= 1'b0;
      y_pulse_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      x_hit     <= (state == RUN) && (lfsr == x_q);
      y_hit     <= (state == RUN) && (lfsr == y_q);
      x_pulse_q <= x_hit && (state != IDLE);
      y_pulse_q <= y_hit && (state != IDLE);
      busy_q    <= (state != IDLE);
      done_q    <= (state == DONE) && !bus.abort;

      case (state)
        IDLE: begin
          if (bus.start) begin
            x_q      <= bus.x_val;
            y_q      <= bus.y_val;
            step_cnt <= '0;
            state    <= RUN;
          end
        end
        RUN: begin
          step_cnt <= step_cnt + 1'b1;
          if (bus.abort) begin
            state <= IDLE;
          end else if (step_cnt == LAST_STEP) begin
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.x_pulse   = x_pulse_q;
  assign bus.y_pulse   = y_pulse_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_lfsr_pulse_gen.sv
// Self-checking bench for lfsr_pulse_gen at WIDTH=4, MASK=4'hC, SEED=1.
module tb_lfsr_pulse_gen;
  import lfsr_pkg::*;

  localparam int W      = 4;
  localparam int PERIOD = 15;

  logic clk;
  logic rst_b;
  int   checks;
  int   errors;

  logic [3:0] exp_q[$];
  logic [3:0] seq [PERIOD] = '{4'h1, 4'hC, 4'h6, 4'h3, 4'hD, 4'hA, 4'h5, 4'hE,
                               4'h7, 4'hF, 4'hB, 4'h9, 4'h8, 4'h4, 4'h2};

  lfsr_pulse_gen_if #(.WIDTH(W)) bus ();

  lfsr_pulse_gen #(
    .WIDTH (W),
    .MASK  (4'hC),
    .SEED  (4'h1)
  ) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic int seq_index(input logic [3:0] v);
    for (int i = 0; i < PERIOD; i++) begin
      if (seq[i] == v) return i;
    end
    return -1;
  endfunction

  // Expected {x_pulse, y_pulse, busy, done} after edge E0+n, n = 0..last.
  task automatic build_model(input logic [3:0] x, input logic [3:0] y,
                             input int ab, input int last_n);
    int xi;
    int yi;
    int stop;
    bit alive;
    xi   = seq_index(x);
    yi   = seq_index(y);
    stop = (ab != 0) ? ab : last_n;
    exp_q.delete();
    for (int n = 0; n <= stop; n++) begin
      alive = (ab == 0) || (n <= ab);
      exp_q.push_back({(xi >= 0) && (n == xi + 2) && alive,
                       (yi >= 0) && (n == yi + 2) && alive,
                       (n >= 1) && (n <= PERIOD + 1) && alive,
                       (n == PERIOD + 1) && (ab == 0 || ab > PERIOD + 1)});
    end
  endtask

  task automatic chk(input string tag, input int n, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s n=%0d observed=%0b expected=%0b", tag, n, got, exp);
    end
  endtask

  task automatic chk_state(input string tag, input state_t exp);
    checks++;
    assert (bus.dbg_state === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, bus.dbg_state, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input int n, input logic [3:0] e);
    chk({tag, ".x_pulse"}, n, bus.x_pulse, e[3]);
    chk({tag, ".y_pulse"}, n, bus.y_pulse, e[2]);
    chk({tag, ".busy"},    n, bus.busy,    e[1]);
    chk({tag, ".done"},    n, bus.done,    e[0]);
  endtask

  task automatic pop_check(input string tag, input int n);
    logic [3:0] e;
    e = exp_q.pop_front();
    check_outputs(tag, n, e);
  endtask

  // Issue start before edge E0, optionally abort at E0+ab and re-issue a
  // (to be ignored) start with fresh operands at E0+late_at.
  task automatic run_sweep(input string tag, input logic [3:0] x, input logic [3:0] y,
                           input int ab, input int late_at, input int last_n);
    int stop;
    stop = (ab != 0) ? ab : last_n;
    build_model(x, y, ab, last_n);
    bus.x_val = x;
    bus.y_val = y;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    pop_check(tag, 0);
    for (int n = 1; n <= stop; n++) begin
      if (n == ab) bus.abort = 1'b1;
      if (n == late_at) begin
        bus.start = 1'b1;
        bus.x_val = 4'($urandom_range(0, 15));
        bus.y_val = 4'($urandom_range(0, 15));
      end
      @(posedge clk);
      #1;
      bus.abort = 1'b0;
      bus.start = 1'b0;
      pop_check(tag, n);
    end
  endtask

  task automatic idle_cycles(input string tag, input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk);
      #1;
      check_outputs(tag, i, 4'b0000);
    end
  endtask

  initial begin
    int ab;
    int late;
    logic [3:0] rx;
    logic [3:0] ry;
    checks    = 0;
    errors    = 0;
    rst_b     = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.x_val = '0;
    bus.y_val = '0;

    #1;
    check_outputs("reset", 0, 4'b0000);
    chk_state("reset.state", IDLE);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    idle_cycles("idle_after_reset", 3);

    // Basic sweep, then a back-to-back start at the earliest legal edge.
    run_sweep("basic", 4'h6, 4'h2, 0, 0, PERIOD + 1);
    run_sweep("back_to_back", 4'hA, 4'h1, 0, 0, PERIOD + 3);

    run_sweep("equal", 4'hD, 4'hD, 0, 0, PERIOD + 3);
    run_sweep("zero", 4'h0, 4'h1, 0, 0, PERIOD + 3);

    // Abort, with a new start accepted on the very next edge.
    run_sweep("abort", 4'h2, 4'h4, 8, 0, 0);
    run_sweep("after_abort", 4'h3, 4'h8, 0, 0, PERIOD + 3);

    run_sweep("start_busy", 4'h6, 4'h2, 0, 5, PERIOD + 3);

    // Reset in the middle of a sweep for x=9.
    build_model(4'h9, 4'h0, 0, 6);
    bus.x_val = 4'h9;
    bus.y_val = 4'h0;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    pop_check("pre_reset", 0);
    for (int n = 1; n <= 6; n++) begin
      @(posedge clk);
      #1;
      pop_check("pre_reset", n);
    end
    #2;
    rst_b = 1'b0;
    #1;
    check_outputs("in_reset", 0, 4'b0000);
    chk_state("in_reset.state", IDLE);
    @(posedge clk);
    #1;
    check_outputs("in_reset", 1, 4'b0000);
    rst_b = 1'b1;
    idle_cycles("post_reset", PERIOD + 2);
    run_sweep("full_after_reset", 4'h9, 4'h0, 0, 0, PERIOD + 3);

    // Randomized sweeps, some aborted, some with starts while busy.
    for (int r = 0; r < 8; r++) begin
      rx   = 4'($urandom_range(0, 15));
      ry   = 4'($urandom_range(0, 15));
      ab   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, PERIOD + 1)) : 0;
      late = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, PERIOD - 1)) : 0;
      if (ab != 0 && late >= ab) late = 0;
      run_sweep("random", rx, ry, ab, late, PERIOD + 3);
    end
    idle_cycles("final_idle", 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
